regfile_wb_arbiter: RTL and testbench

Shares the single write port of the 64-bit, 32-entry register file between two writeback sources: the ALU pipe (req0) and the long-latency memory/multiply unit (req1). Grants one write per cycle with fixed priority to req0 and a starvation override for req1. Registers the winning write onto the register-file write port and keeps a pending-write scoreboard. Issue logic uses the scoreboard hazard outputs to stall dependent instructions.

---
 rtl/regfile_wb_arbiter.sv | 93 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the shared register-file write port.
// Fixed priority to req0 with a starvation override for req1, plus a pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int MAX_WAIT = 4,
    localparam int RW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic [RW-1:0]   req0_rd,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [RW-1:0]   req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    input  logic            issue_valid,
    input  logic [RW-1:0]   issue_rd,
    input  logic [RW-1:0]   chk_rs1,
    input  logic [RW-1:0]   chk_rs2,
    output logic            hazard_rs1,
    output logic            hazard_rs2,
    output logic            rf_reg_write,
    output logic [RW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_writedata,
    output logic [NREG-1:0] pending
);

    logic [3:0]      wait_cnt;
    logic [3:0]      wait_next;
    logic            starve;
    logic            grant;
    logic [RW-1:0]   grant_rd;
    logic [XLEN-1:0] grant_data;
    logic [NREG-1:0] pending_next;

    assign starve = (wait_cnt >= 4'(MAX_WAIT));

    assign req0_ready = req0_valid && !(starve && req1_valid) && !reset;
    assign req1_ready = req1_valid && (!req0_valid || starve) && !reset;

    assign grant      = req0_ready || req1_ready;
    assign grant_rd   = req1_ready ? req1_rd : req0_rd;
    assign grant_data = req1_ready ? req1_data : req0_data;

    // Count only cycles where req1 is actually blocked.
    always_comb begin
        wait_next = wait_cnt;
        if (req1_ready || !req1_valid) begin
            wait_next = '0;
        end else if (wait_cnt != 4'hF) begin
            wait_next = wait_cnt + 4'd1;
        end
    end

    // A new producer supersedes the write that is retiring this cycle.
    always_comb begin
        pending_next = pending;
        for (int i = 0; i < NREG; i++) begin
            if (rf_reg_write && rf_rd == RW'(i)) begin
                pending_next[i] = 1'b0;
            end
            if (issue_valid && issue_rd == RW'(i)) begin
                pending_next[i] = 1'b1;
            end
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt     <= '0;
            rf_reg_write <= 1'b0;
            rf_rd        <= '0;
            rf_writedata <= '0;
            pending      <= '0;
        end else begin
            wait_cnt     <= wait_next;
            rf_reg_write <= grant && (grant_rd != '0);
            pending      <= pending_next;
            if (grant) begin
                rf_rd        <= grant_rd;
                rf_writedata <= grant_data;
            end
        end
    end

    assign hazard_rs1 = pending[chk_rs1];
    assign hazard_rs2 = pending[chk_rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus queues expected writes,
// a negedge monitor compares each register-file write against them.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [4:0]  req0_rd;
    logic [63:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_rd;
    logic [63:0] req1_data;
    logic        req1_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        hazard_rs1;
    logic        hazard_rs2;
    logic        rf_reg_write;
    logic [4:0]  rf_rd;
    logic [63:0] rf_writedata;
    logic [31:0] pending;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    regfile_wb_arbiter #(.XLEN(64), .NREG(32), .MAX_WAIT(4)) dut (
        .clk(clk),
        .reset(reset),
        .req0_valid(req0_valid),
        .req0_rd(req0_rd),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_rd(req1_rd),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .chk_rs1(chk_rs1),
        .chk_rs2(chk_rs2),
        .hazard_rs1(hazard_rs1),
        .hazard_rs2(hazard_rs2),
        .rf_reg_write(rf_reg_write),
        .rf_rd(rf_rd),
        .rf_writedata(rf_writedata),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [63:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: every committed write must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && rf_reg_write) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual_rd=%0d actual_data=%0h required=none",
                         rf_rd, rf_writedata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_rd", 64'(rf_rd), 64'(w.rd));
                chk("wr_data", rf_writedata, w.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        req0_valid  = 1'b1;
        req0_rd     = 5'd5;
        req0_data   = 64'hAB;
        req1_valid  = 1'b1;
        req1_rd     = 5'd7;
        req1_data   = 64'h77;
        issue_valid = 1'b0;
        issue_rd    = '0;
        chk_rs1     = '0;
        chk_rs2     = '0;

        // Reset with both requests asserted
        cyc();
        mid();
        chk("rst_r0", 64'(req0_ready), 64'd0);
        chk("rst_r1", 64'(req1_ready), 64'd0);
        chk("rst_we", 64'(rf_reg_write), 64'd0);
        chk("rst_pend", 64'(pending), 64'd0);
        cyc();

        // Priority and starvation: cycle 0 is the first cycle out of reset
        reset = 1'b0;
        mid();
        chk("c0_r0", 64'(req0_ready), 64'd1);
        chk("c0_r1", 64'(req1_ready), 64'd0);
        push(5'd5, 64'hAB);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            req0_rd   = 5'(c);
            req0_data = 64'h100 + 64'(c);
            mid();
            chk("pri_r0", 64'(req0_ready), 64'd1);
            chk("pri_r1", 64'(req1_ready), 64'd0);
            push(5'(c), 64'h100 + 64'(c));
            if (c == 1) begin
                chk("post_rst_we", 64'(rf_reg_write), 64'd1);
                chk("post_rst_rd", 64'(rf_rd), 64'd5);
                chk("post_rst_data", rf_writedata, 64'hAB);
            end
        end
        cyc();
        req0_rd   = 5'd4;
        req0_data = 64'h104;
        mid();
        chk("starve_r0", 64'(req0_ready), 64'd0);
        chk("starve_r1", 64'(req1_ready), 64'd1);
        push(5'd7, 64'h77);
        cyc();
        req1_valid = 1'b0;
        mid();
        chk("resume_r0", 64'(req0_ready), 64'd1);
        chk("resume_we", 64'(rf_reg_write), 64'd1);
        chk("wait_clr", 64'(dut.wait_cnt), 64'd0);
        push(5'd4, 64'h104);
        cyc();
        req0_valid = 1'b0;
        mid();
        chk("idle_r0", 64'(req0_ready), 64'd0);

        // Scoreboard lifecycle on x9
        cyc();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        chk_rs1     = 5'd9;
        chk_rs2     = 5'd10;
        mid();
        chk("sb_c0_haz", 64'(hazard_rs1), 64'd0);
        cyc();
        issue_valid = 1'b0;
        mid();
        chk("sb_c1_haz", 64'(hazard_rs1), 64'd1);
        chk("sb_c1_rs2", 64'(hazard_rs2), 64'd0);
        chk("sb_c1_pend", 64'(pending), 64'h200);
        cyc();
        mid();
        chk("sb_c2_haz", 64'(hazard_rs1), 64'd1);
        cyc();
        req1_valid = 1'b1;
        req1_rd    = 5'd9;
        req1_data  = 64'h999;
        mid();
        chk("sb_c3_r1", 64'(req1_ready), 64'd1);
        chk("sb_c3_haz", 64'(hazard_rs1), 64'd1);
        push(5'd9, 64'h999);
        cyc();
        req1_valid = 1'b0;
        mid();
        chk("sb_c4_we", 64'(rf_reg_write), 64'd1);
        chk("sb_c4_haz", 64'(hazard_rs1), 64'd1);
        cyc();
        mid();
        chk("sb_c5_haz", 64'(hazard_rs1), 64'd0);
        chk("sb_c5_pend", 64'(pending), 64'd0);

        // Set and clear of x9 in the same cycle: set wins
        cyc();
        req0_valid = 1'b1;
        req0_rd    = 5'd9;
        req0_data  = 64'h5A5;
        mid();
        chk("col_r0", 64'(req0_ready), 64'd1);
        push(5'd9, 64'h5A5);
        cyc();
        req0_valid  = 1'b0;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        mid();
        chk("col_we", 64'(rf_reg_write), 64'd1);
        cyc();
        issue_valid = 1'b0;
        mid();
        chk("col_pend9", 64'(pending[9]), 64'd1);
        chk("col_haz", 64'(hazard_rs1), 64'd1);
        cyc();
        req1_valid = 1'b1;
        req1_rd    = 5'd9;
        req1_data  = 64'h123;
        mid();
        push(5'd9, 64'h123);
        cyc();
        req1_valid = 1'b0;
        cyc();
        mid();
        chk("col_clr", 64'(pending), 64'd0);

        // x0: accepted but never written, never pending
        cyc();
        req0_valid = 1'b1;
        req0_rd    = 5'd0;
        req0_data  = 64'hDEAD;
        mid();
        chk("x0_r0", 64'(req0_ready), 64'd1);
        cyc();
        req0_valid  = 1'b0;
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        chk_rs1     = 5'd0;
        chk_rs2     = 5'd0;
        mid();
        chk("x0_we", 64'(rf_reg_write), 64'd0);
        cyc();
        issue_valid = 1'b0;
        mid();
        chk("x0_pend", 64'(pending), 64'd0);
        chk("x0_haz1", 64'(hazard_rs1), 64'd0);
        chk("x0_haz2", 64'(hazard_rs2), 64'd0);

        // Reset while a write to x12 is in flight
        cyc();
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        chk_rs1     = 5'd12;
        cyc();
        issue_valid = 1'b0;
        req1_valid  = 1'b1;
        req1_rd     = 5'd12;
        req1_data   = 64'hC0C;
        mid();
        chk("mf_r1", 64'(req1_ready), 64'd1);
        chk("mf_pend12", 64'(pending[12]), 64'd1);
        cyc();
        req1_valid = 1'b0;
        reset      = 1'b1;
        req0_valid = 1'b1;
        req0_rd    = 5'd3;
        req0_data  = 64'h333;
        mid();
        chk("mf_rst_r0", 64'(req0_ready), 64'd0);
        cyc();
        reset      = 1'b0;
        req0_valid = 1'b0;
        mid();
        chk("mf_we", 64'(rf_reg_write), 64'd0);
        chk("mf_pend", 64'(pending), 64'd0);
        chk("mf_haz", 64'(hazard_rs1), 64'd0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            cyc();
        end
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
